// File: rtl/spi_reg_ctrl_if.sv
// Bundle of command, response, AXIS and chip-select signals around spi_reg_ctrl.
// slave = the sequencer's view, master = the view of the surrounding system/bench.
interface spi_reg_ctrl_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int CS_CNT_WIDTH = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_rw;
  logic [DATA_WIDTH-2:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_error;

  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  logic [CS_CNT_WIDTH-1:0] cs_setup;
  logic [CS_CNT_WIDTH-1:0] cs_hold;
  logic [CS_CNT_WIDTH-1:0] cs_gap;
  logic                    cs_n;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  m_axis_tready, s_axis_tdata, s_axis_tvalid,
    input  cs_setup, cs_hold, cs_gap,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output m_axis_tdata, m_axis_tvalid, s_axis_tready,
    output cs_n, busy
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output rsp_ready,
    output m_axis_tready, s_axis_tdata, s_axis_tvalid,
    output cs_setup, cs_hold, cs_gap,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  m_axis_tdata, m_axis_tvalid, s_axis_tready,
    input  cs_n, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer: one command -> cs_n-framed {rw,addr} + data SPI frame.
// Define SPI_REG_CTRL_TIMEOUT_EN to add the 16-bit rx watchdog and rsp_error.
module spi_reg_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int CS_CNT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  spi_reg_ctrl_if.slave bus
);

  localparam int AW = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, HDR, HWAIT, DATA, DWAIT, HOLD, RESP
  } state_t;

  // Every counted state lasts at least one cycle, so 0 and 1 both mean one cycle.
  function automatic logic cnt_last(input logic [CS_CNT_WIDTH-1:0] c);
    return (c <= CS_CNT_WIDTH'(1));
  endfunction

  function automatic logic [CS_CNT_WIDTH-1:0] cnt_dec(input logic [CS_CNT_WIDTH-1:0] c);
    return (c == '0) ? '0 : c - CS_CNT_WIDTH'(1);
  endfunction

  state_t                  state_q, state_d;
  logic [CS_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    cs_n_q, cs_n_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    tvalid_q, tvalid_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    rw_q, rw_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
  logic [15:0]             wdog_q, wdog_d;
  logic                    err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_n_d      = cs_n_q;
    tvalid_d    = tvalid_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tdata_d     = tdata_q;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
    err_d       = err_q;
    wdog_d      = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          rw_d    = bus.cmd_rw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          cnt_d   = bus.cs_setup;
          cs_n_d  = 1'b0;
          state_d = SETUP;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cnt_last(cnt_q)) begin
          tvalid_d = 1'b1;
          tdata_d  = {rw_q, addr_q};
          state_d  = HDR;
        end else begin
          cnt_d = cnt_dec(cnt_q);
        end
      end
      HDR: begin
        if (bus.m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = HWAIT;
        end
      end
      HWAIT: begin
        if (bus.s_axis_tvalid) begin
          tvalid_d = 1'b1;
          tdata_d  = rw_q ? '0 : wdata_q;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bus.m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = DWAIT;
        end
      end
      DWAIT: begin
        if (bus.s_axis_tvalid) begin
          rdata_d = bus.s_axis_tdata;
          cnt_d   = bus.cs_hold;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_last(cnt_q)) begin
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          cnt_d       = bus.cs_gap;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_dec(cnt_q);
        end
      end
      RESP: begin
        // Response handshake and cs_n gap run in parallel; leave only when both are done.
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
        cnt_d = cnt_dec(cnt_q);
        if ((!rsp_valid_q || bus.rsp_ready) && cnt_last(cnt_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    // wdog counts cycles already spent in the wait state; 0xFFFE here means 0xFFFF cycles.
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (state_q == HWAIT || state_q == DWAIT) begin
      if (wdog_q == 16'hFFFE) begin
        rdata_d = '0;
        err_d   = 1'b1;
        cnt_d   = bus.cs_hold;
        wdog_d  = '0;
        state_d = HOLD;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end
`endif

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  // Command and outgoing word registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    tdata_q <= tdata_d;
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.busy          = busy_q;
  assign bus.cs_n          = cs_n_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.s_axis_tready = 1'b1;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rdata_q;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
  assign bus.rsp_error     = err_q;
`else
  assign bus.rsp_error     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: behavioural spi_master/slave stub, vector table, random frames.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
  localparam int DW  = 8;
  localparam int CCW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_ctrl_if #(.DATA_WIDTH(DW), .CS_CNT_WIDTH(CCW)) bus();
  spi_reg_ctrl #(.DATA_WIDTH(DW), .CS_CNT_WIDTH(CCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit         rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso1;
    int         setup;
    int         hold;
    int         gap;
    logic [7:0] exp_hdr;
    logic [7:0] exp_data;
    logic [7:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] miso_q[$];
  logic [DW-1:0] mosi_q[$];
  int word_cyc = 6;
  bit stall = 1'b0;

  int cyc = 0, fall_cyc = 0, tv_cyc = 0, rx_cyc = 0, rise_cyc = 0, gap_len = 0, rdy_cyc = 0;
  bit seen_tv = 1'b0, seen_rdy = 1'b0;
  logic cs_prev = 1'b1;
  int prev_gap = 0;
  bit prev_ok = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input longint act, input longint min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic int at_least1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Reference: frame content follows directly from the command.
  function automatic vec_t model(input bit rw, input logic [6:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] miso1, input int s, input int h, input int g);
    vec_t r;
    r.rw = rw; r.addr = addr; r.wdata = wdata; r.miso1 = miso1;
    r.setup = s; r.hold = h; r.gap = g;
    r.exp_hdr   = 8'((rw ? 128 : 0) + int'(addr));
    r.exp_data  = rw ? 8'd0 : wdata;
    r.exp_rdata = miso1;
    return r;
  endfunction

  function automatic vec_t mk(input bit rw, input int addr, input int wdata, input int miso1,
                              input int s, input int h, input int g,
                              input int eh, input int ed, input int er);
    vec_t r;
    r.rw = rw; r.addr = 7'(addr); r.wdata = 8'(wdata); r.miso1 = 8'(miso1);
    r.setup = s; r.hold = h; r.gap = g;
    r.exp_hdr = 8'(eh); r.exp_data = 8'(ed); r.exp_rdata = 8'(er);
    return r;
  endfunction

  // Stub spi_master + slave: accepts a word, returns the next miso word word_cyc cycles later.
  initial begin : master_model
    bit hs;
    logic [DW-1:0] w;
    int cnt;
    cnt = 0;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = bus.m_axis_tvalid && bus.m_axis_tready;
      w  = bus.m_axis_tdata;
      @(posedge clk);
      #1;
      bus.s_axis_tvalid = 1'b0;
      if (hs) begin
        mosi_q.push_back(w);
        bus.m_axis_tready = 1'b0;
        cnt = word_cyc;
      end else if (!bus.m_axis_tready && !stall) begin
        if (cnt <= 1) begin
          bus.s_axis_tvalid = 1'b1;
          bus.s_axis_tdata  = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
          bus.m_axis_tready = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (cs_prev && !bus.cs_n) begin
        fall_cyc = cyc; seen_tv = 1'b0; gap_len = cyc - rise_cyc;
      end
      if (!cs_prev && bus.cs_n) begin
        rise_cyc = cyc; seen_rdy = 1'b0;
      end
      if (!bus.cs_n && bus.m_axis_tvalid && !seen_tv) begin
        tv_cyc = cyc; seen_tv = 1'b1;
      end
      if (!bus.cs_n && bus.s_axis_tvalid) rx_cyc = cyc;
      if (bus.cs_n && bus.cmd_ready && !seen_rdy) begin
        rdy_cyc = cyc; seen_rdy = 1'b1;
      end
      cs_prev = bus.cs_n;
    end
  end

  task automatic issue(input vec_t v, input bit rdy, input string tag);
    int n;
    mosi_q.delete();
    miso_q.delete();
    miso_q.push_back(8'($urandom));
    miso_q.push_back(v.miso1);
    @(posedge clk);
    #1;
    bus.cs_setup  = CCW'(v.setup);
    bus.cs_hold   = CCW'(v.hold);
    bus.cs_gap    = CCW'(v.gap);
    bus.cmd_rw    = v.rw;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.rsp_ready = rdy;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      wait_neg();
      n++;
    end while (!bus.cmd_ready && n < 200);
    if (!bus.cmd_ready) chk({tag, " cmd_accept"}, bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (12) wait_neg();
    mosi_q.delete();
    miso_q.delete();
  endtask

  task automatic run_txn(input vec_t v, input int rdy_hold, input string tag);
    int n;
    bit ok;
    issue(v, rdy_hold == 0, tag);
    wait_neg();
    chk({tag, " busy"}, bus.busy, 1);
    chk({tag, " cs_low"}, bus.cs_n, 0);
    if (prev_ok && prev_gap > 0) begin
      chk_ge({tag, " cs_gap"}, gap_len, prev_gap);
      chk_ge({tag, " rdy_gap"}, rdy_cyc - rise_cyc, prev_gap);
    end
    n = 0;
    while (!bus.rsp_valid && n < 4000) begin
      wait_neg();
      n++;
    end
    chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, " rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, " error"}, bus.rsp_error, 0);
    chk({tag, " cs_high_at_rsp"}, bus.cs_n, 1);
    if (rdy_hold > 0) begin
      ok = 1'b1;
      repeat (rdy_hold) begin
        wait_neg();
        if (!(bus.rsp_valid && bus.rsp_rdata == v.exp_rdata && bus.cs_n &&
              !bus.cmd_ready && !bus.m_axis_tvalid)) ok = 1'b0;
      end
      chk({tag, " stall_stable"}, ok, 1);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      wait_neg();
      wait_neg();
      chk({tag, " rsp_drop"}, bus.rsp_valid, 0);
    end
    chk({tag, " mosi_cnt"}, mosi_q.size(), 2);
    chk({tag, " mosi_hdr"}, (mosi_q.size() > 0) ? longint'(mosi_q[0]) : -1, v.exp_hdr);
    chk({tag, " mosi_data"}, (mosi_q.size() > 1) ? longint'(mosi_q[1]) : -1, v.exp_data);
    chk({tag, " setup_lead"}, tv_cyc - fall_cyc, at_least1(v.setup));
    // rx word is sampled on the edge after the negedge where it is seen
    chk({tag, " hold_tail"}, rise_cyc - rx_cyc, at_least1(v.hold) + 1);
    prev_gap = v.gap;
    prev_ok  = 1'b1;
  endtask

  initial begin : safety
    #3ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    vec_t tbl[5];
    vec_t r;
    int n;

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1; bus.cs_setup = '0; bus.cs_hold = '0; bus.cs_gap = '0;

    //             rw addr  wdata miso  s  h  g  hdr   data  rdata
    tbl[0] = mk(0, 'h15, 'hA5, 'h5A, 2, 3, 0, 'h15, 'hA5, 'h5A);
    tbl[1] = mk(1, 'h7F, 'h99, 'h3C, 0, 0, 0, 'hFF, 'h00, 'h3C);
    tbl[2] = mk(0, 'h00, 'hFF, 'h00, 1, 1, 1, 'h00, 'hFF, 'h00);
    tbl[3] = mk(1, 'h2A, 'h11, 'hC3, 5, 0, 2, 'hAA, 'h00, 'hC3);
    tbl[4] = mk(0, 'h7F, 'h00, 'hFF, 0, 4, 0, 'h7F, 'h00, 'hFF);

    repeat (3) @(posedge clk);
    wait_neg();
    chk("rst cs_n", bus.cs_n, 1);
    chk("rst cmd_ready", bus.cmd_ready, 0);
    chk("rst tvalid", bus.m_axis_tvalid, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rdata", bus.rsp_rdata, 0);
    chk("rst error", bus.rsp_error, 0);
    chk("rst busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(tbl[i], 0, $sformatf("vec%0d", i));

    // back-to-back frames with a 4-cycle chip-select gap
    run_txn(model(0, 7'h33, 8'h5C, 8'hE7, 1, 1, 4), 0, "b2b_a");
    run_txn(model(1, 7'h44, 8'h00, 8'h81, 1, 1, 4), 0, "b2b_b");
    chk_ge("b2b explicit_gap", gap_len, 4);

    // response held off for 20 cycles
    run_txn(model(1, 7'h12, 8'h00, 8'h6D, 2, 2, 0), 20, "rsp_stall");

    // reset while the data word is being offered
    issue(model(0, 7'h21, 8'h77, 8'h42, 1, 1, 0), 1'b1, "rst_mid");
    n = 0;
    while (!(mosi_q.size() == 1 && bus.m_axis_tvalid) && n < 200) begin
      wait_neg();
      n++;
    end
    chk("rst_mid reached_data", bus.m_axis_tvalid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_neg();
    chk("rst_mid cs_n", bus.cs_n, 1);
    chk("rst_mid busy", bus.busy, 0);
    chk("rst_mid tvalid", bus.m_axis_tvalid, 0);
    chk("rst_mid rsp_valid", bus.rsp_valid, 0);
    flush();
    prev_ok = 1'b0;
    run_txn(tbl[0], 0, "after_rst");

    for (int i = 0; i < 12; i++) begin
      word_cyc = int'($urandom_range(1, 8));
      r = model(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
      run_txn(r, 0, $sformatf("rnd%0d", i));
    end

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    word_cyc = 4;
    stall = 1'b1;
    issue(model(1, 7'h0F, 8'h00, 8'h99, 0, 1, 0), 1'b1, "timeout");
    n = 0;
    while (!bus.rsp_valid && n < 70000) begin
      wait_neg();
      n++;
    end
    chk("timeout rsp_valid", bus.rsp_valid, 1);
    chk("timeout error", bus.rsp_error, 1);
    chk("timeout rdata", bus.rsp_rdata, 0);
    chk("timeout cs_n", bus.cs_n, 1);
    chk_ge("timeout wait_len", n, 65000);
    wait_neg();
    wait_neg();
    chk("timeout idle", bus.busy, 0);
    stall = 1'b0;
    flush();
    prev_ok = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
